// File: rtl/key_digit_entry.sv
// key_digit_entry: synchronizes and debounces the enter/clear buttons
// and assembles two switch digits into an 8-bit code for the matcher.
module key_digit_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       clr_n,
  input  logic [3:0] sw_digit,
  output logic [7:0] digits,
  output logic       digits_valid,
  output logic [1:0] digit_count,
  output logic       entry_pulse
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_key_m;
  logic             r_key_s;
  logic             r_clr_m;
  logic             r_clr_s;
  logic [3:0]       r_sw_m;
  logic [3:0]       r_sw_s;
  logic             r_key_db;
  logic [CNT_W-1:0] r_cnt;
  state_t           r_state;
  logic [7:0]       r_digits;
  logic             r_valid;
  logic             r_pulse;

  state_t           w_state_nx;
  logic [7:0]       w_digits_nx;
  logic             w_pulse_nx;
  logic             w_fall;

  // Two-flop synchronizers for every raw board input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_m <= 1'b1;
      r_key_s <= 1'b1;
      r_clr_m <= 1'b1;
      r_clr_s <= 1'b1;
      r_sw_m  <= 4'h0;
      r_sw_s  <= 4'h0;
    end else begin
      r_key_m <= key_n;
      r_key_s <= r_key_m;
      r_clr_m <= clr_n;
      r_clr_s <= r_clr_m;
      r_sw_m  <= sw_digit;
      r_sw_s  <= r_sw_m;
    end
  end

  // Accept a key level only after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_key_db <= 1'b1;
      r_cnt    <= '0;
    end else if (r_key_s == r_key_db) begin
      r_cnt <= '0;
    end else if (r_cnt == LP_LAST) begin
      r_key_db <= r_key_s;
      r_cnt    <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A debounced press is the edge where key_db drops to 0.
  assign w_fall = r_key_db & ~r_key_s &
                  (r_cnt == LP_LAST);

  // Next-state and digit assembly; clear overrides any entry.
  always_comb begin
    w_state_nx  = r_state;
    w_digits_nx = r_digits;
    w_pulse_nx  = 1'b0;
    if (!r_clr_s) begin
      w_state_nx  = S_EMPTY;
      w_digits_nx = 8'h00;
    end else if (w_fall) begin
      w_pulse_nx = 1'b1;
      unique case (r_state)
        S_ONE: begin
          w_digits_nx = {r_digits[3:0], r_sw_s};
          w_state_nx  = S_FULL;
        end
        default: begin
          w_digits_nx = {4'h0, r_sw_s};
          w_state_nx  = S_ONE;
        end
      endcase
    end
  end

  // State, code and handshake registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_EMPTY;
      r_digits <= 8'h00;
      r_valid  <= 1'b0;
      r_pulse  <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_digits <= w_digits_nx;
      r_valid  <= (w_state_nx == S_FULL);
      r_pulse  <= w_pulse_nx;
    end
  end

  assign digits       = r_digits;
  assign digits_valid = r_valid;
  assign digit_count  = r_state;
  assign entry_pulse  = r_pulse;

endmodule

// File: tb/tb_key_digit_entry.sv
// tb_key_digit_entry: scenario tasks plus a run-length reference
// model of the two-digit entry behaviour.
module tb_key_digit_entry;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_n = 1'b1;
  logic       clr_n = 1'b1;
  logic [3:0] sw_digit = 4'h0;
  logic [7:0] digits;
  logic       digits_valid;
  logic [1:0] digit_count;
  logic       entry_pulse;

  int total = 0;
  int bad = 0;

  key_digit_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
    .clk(clk),
    .reset(reset),
    .key_n(key_n),
    .clr_n(clr_n),
    .sw_digit(sw_digit),
    .digits(digits),
    .digits_valid(digits_valid),
    .digit_count(digit_count),
    .entry_pulse(entry_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: inputs arrive two edges late; a level is
  // accepted after D consecutive differing samples; held digits
  // live in a queue, oldest first.
  int       m_run;
  bit       m_km, m_ks, m_cm, m_cs, m_db, m_ent, m_pulse;
  bit [3:0] m_swm, m_sws;
  bit [3:0] m_q[$];

  always @(posedge clk) begin
    if (reset) begin
      m_km = 1; m_ks = 1; m_cm = 1; m_cs = 1; m_db = 1;
      m_swm = 0; m_sws = 0; m_run = 0; m_pulse = 0;
      m_q.delete();
    end else begin
      m_ent = 0;
      if (m_ks != m_db) begin
        m_run++;
        if (m_run == D) begin
          m_db = m_ks;
          m_run = 0;
          m_ent = !m_db;
        end
      end else m_run = 0;
      m_pulse = 0;
      if (!m_cs) m_q.delete();
      else if (m_ent) begin
        if (m_q.size() == 2) m_q.delete();
        m_q.push_back(m_sws);
        m_pulse = 1;
      end
      m_ks = m_km; m_km = key_n;
      m_cs = m_cm; m_cm = clr_n;
      m_sws = m_swm; m_swm = sw_digit;
    end
  end

  function automatic logic [11:0] model_vec();
    logic [7:0] d;
    d = 8'h00;
    if (m_q.size() == 1) d = {4'h0, m_q[0]};
    if (m_q.size() == 2) d = {m_q[0], m_q[1]};
    return {d, 2'(m_q.size()), m_q.size() == 2, m_pulse};
  endfunction

  task automatic test_reset();
    logic [11:0] obs;
    reset = 1; key_n = 1; clr_n = 1; sw_digit = 0;
    repeat (2) @(negedge clk);
    obs = {digits, digit_count, digits_valid, entry_pulse};
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL reset_state got=%h want=000", obs);
    end
    reset = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (entry_pulse !== 1'b0 || digit_count !== 2'd0) begin
        bad++;
        $display("FAIL idle_no_pulse cyc=%0d pulse=%b cnt=%0d want 0/0",
                 i, entry_pulse, digit_count);
      end
    end
  endtask

  task automatic test_entry();
    logic [11:0] obs;
    sw_digit = 4'h4; key_n = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      total++;
      if (entry_pulse !== (e == 5)) begin
        bad++;
        $display("FAIL first_latency edge=%0d got=%b want=%b",
                 e, entry_pulse, e == 5);
      end
    end
    obs = {digits, digit_count, digits_valid, entry_pulse};
    total++;
    if (obs !== {8'h04, 2'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL first_digit got=%h want=044", obs);
    end
    key_n = 1;
    repeat (10) @(negedge clk);
    sw_digit = 4'h3; key_n = 0;
    repeat (10) @(negedge clk);
    key_n = 1;
    repeat (10) @(negedge clk);
    obs = {digits, digit_count, digits_valid, entry_pulse};
    total++;
    if (obs !== {8'h43, 2'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL second_digit got=%h want=%h",
               obs, {8'h43, 2'd2, 1'b1, 1'b0});
    end
  endtask

  task automatic test_bounce();
    int pc;
    logic [11:0] obs;
    pc = 0;
    for (int i = 0; i < 30; i++) begin
      key_n = (i < 20) ? ((i / 2) % 2 == 1) : 1'b1;
      @(negedge clk);
      if (entry_pulse === 1'b1) pc++;
    end
    key_n = 0;
    repeat (3) @(negedge clk) if (entry_pulse === 1'b1) pc++;
    key_n = 1;
    repeat (10) @(negedge clk) if (entry_pulse === 1'b1) pc++;
    obs = {digits, digit_count, digits_valid, entry_pulse};
    total++;
    if (pc != 0 || obs !== {8'h43, 2'd2, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL bounce pulses=%0d got=%h want 0 pulses/%h",
               pc, obs, {8'h43, 2'd2, 1'b1, 1'b0});
    end
  endtask

  task automatic test_full_restart();
    int pc;
    logic [11:0] obs;
    pc = 0;
    sw_digit = 4'h9; key_n = 0;
    repeat (6) @(negedge clk) if (entry_pulse === 1'b1) pc++;
    key_n = 1;
    repeat (10) @(negedge clk) if (entry_pulse === 1'b1) pc++;
    obs = {digits, digit_count, digits_valid, entry_pulse};
    total++;
    if (pc != 1 || obs !== {8'h09, 2'd1, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL full_restart pulses=%0d got=%h want 1 pulse/%h",
               pc, obs, {8'h09, 2'd1, 1'b0, 1'b0});
    end
  endtask

  task automatic test_clear();
    int pc;
    logic [11:0] obs;
    sw_digit = 4'h1; key_n = 0;
    repeat (8) @(negedge clk);
    key_n = 1;
    repeat (8) @(negedge clk);
    total++;
    if (digits !== 8'h91 || digit_count !== 2'd2) begin
      bad++;
      $display("FAIL pre_clear got=%h/%0d want=91/2",
               digits, digit_count);
    end
    clr_n = 0;
    @(negedge clk);
    clr_n = 1;
    repeat (2) @(negedge clk);
    obs = {digits, digit_count, digits_valid, entry_pulse};
    total++;
    if (obs !== 12'h000) begin
      bad++;
      $display("FAIL clear got=%h want=000", obs);
    end
    sw_digit = 4'h7; key_n = 0;
    repeat (8) @(negedge clk);
    key_n = 1;
    repeat (8) @(negedge clk);
    total++;
    if (digits !== 8'h07 || digit_count !== 2'd1) begin
      bad++;
      $display("FAIL pre_collide got=%h/%0d want=07/1",
               digits, digit_count);
    end
    pc = 0;
    sw_digit = 4'h5; key_n = 0;
    for (int e = 0; e < 10; e++) begin
      clr_n = (e != 3);
      @(negedge clk);
      if (entry_pulse === 1'b1) pc++;
    end
    clr_n = 1;
    key_n = 1;
    repeat (8) @(negedge clk) if (entry_pulse === 1'b1) pc++;
    obs = {digits, digit_count, digits_valid, entry_pulse};
    total++;
    if (pc != 0 || obs !== 12'h000) begin
      bad++;
      $display("FAIL clear_collide pulses=%0d got=%h want 0/000",
               pc, obs);
    end
  endtask

  task automatic test_reset_hold();
    int pc;
    sw_digit = 4'hA; key_n = 0; reset = 1;
    repeat (3) @(negedge clk);
    reset = 0;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      total++;
      if (entry_pulse !== (e == 5)) begin
        bad++;
        $display("FAIL reset_hold edge=%0d got=%b want=%b",
                 e, entry_pulse, e == 5);
      end
    end
    pc = 0;
    repeat (50) @(negedge clk) if (entry_pulse === 1'b1) pc++;
    total++;
    if (pc != 0 || digits !== 8'h0A) begin
      bad++;
      $display("FAIL held_no_repeat pulses=%0d digits=%h want 0/0a",
               pc, digits);
    end
    key_n = 1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    logic [11:0] obs;
    logic [11:0] expv;
    int len;
    for (int it = 0; it < 60; it++) begin
      sw_digit = 4'($urandom);
      key_n = $urandom_range(0, 1);
      clr_n = ($urandom_range(0, 9) != 0);
      len = $urandom_range(1, 7);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        obs = {digits, digit_count, digits_valid, entry_pulse};
        expv = model_vec();
        total++;
        if (obs !== expv) begin
          bad++;
          $display("FAIL random it=%0d got=%h want=%h", it, obs, expv);
        end
        clr_n = 1;
      end
    end
    key_n = 1; clr_n = 1;
    repeat (10) @(negedge clk);
    obs = {digits, digit_count, digits_valid, entry_pulse};
    expv = model_vec();
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL random_settle got=%h want=%h", obs, expv);
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_bounce();
    test_full_restart();
    test_clear();
    test_reset_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/key_digit_entry.md
Name: key_digit_entry

Overview:
- Input-conditioning and digit-entry stage that sits directly upstream of the board's two-digit switch matcher.
- Raw active-low pushbutton and switch inputs are synchronized and debounced. Each debounced press captures a 4-bit digit from the switches into a two-digit register.
- The block presents the assembled 8-bit code with a valid flag, replacing direct switch-to-matcher wiring.
- Upper digit [7:4] is the first entered and lower digit [3:0] the second, matching the matcher's SW[7:4]/SW[3:0] layout.

Parameters:
DEBOUNCE_CYCLES, 16, consecutive stable cycles before a key level change is accepted (board build uses 500000; must be >= 2).
CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES-1.

Ports:
clk  input  1  system clock (CLOCK_50 on the board).
reset  input  1  synchronous, active-high reset.
key_n  input  1  raw enter pushbutton, active-low, asynchronous, bouncy.
clr_n  input  1  raw clear pushbutton, active-low, asynchronous (not debounced).
sw_digit  input  4  raw switch value for the digit being entered.
digits  output  8  assembled code: [7:4] first digit, [3:0] second digit.
digits_valid  output  1  high while two digits are held.
digit_count  output  2  number of digits held: 0, 1 or 2.
entry_pulse  output  1  one-cycle pulse on each accepted digit entry.

Behaviour:
- Clock and reset: single clock domain; reset is synchronous, active-high.
- Reset values:
  - digits=0, digits_valid=0, digit_count=0, entry_pulse=0.
  - key/clr synchronizer flops=1, sw synchronizer=0, debounced key=1, debounce counter=0.
- Synchronizers: 2-flop synchronizers on key_n, clr_n and sw_digit (4 bits). All internal logic uses the synchronized copies (key_s, clr_s, sw_s).
- Debounce, per clock edge:
  - If key_s == key_db, counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1, key_db <= key_s and counter <= 0.
  - Else counter <= counter+1.
  - Any bounce back to key_db before the threshold restarts the count.
- Latency: key_n low first sampled at edge 0 and held → key_db falls at edge DEBOUNCE_CYCLES+1. Release (rising) is debounced identically.
- Press acceptance: the edge where key_db goes 1→0 is an entry. A 0→1 transition produces no entry.
- On that entry edge, entry_pulse <= 1 for exactly one cycle, and digits/digit_count update on the same edge, using sw_s as sampled at that edge.
- FSM (state mirrors digit_count):
  - EMPTY (0): entry → digits <= {4'h0, sw_s}; go to ONE.
  - ONE (1): entry → digits <= {digits[3:0], sw_s}; go to FULL; digits_valid <= 1.
  - FULL (2): entry → restart: digits <= {4'h0, sw_s}; go to ONE; digits_valid <= 0.
- Clear: while clr_s == 0, state → EMPTY, digits <= 0, digits_valid <= 0.
  - An entry on the same edge is discarded: entry_pulse stays 0. Clear dominates.
  - Debouncing continues during clear.
- Reset mid-debounce: counter and key_db return to reset values. A key held low through reset release yields exactly one entry, DEBOUNCE_CYCLES+1 edges after the first sampled low following release.
- Holding key_n low indefinitely produces exactly one entry; a new entry requires a debounced release first.
- digits_valid == (digit_count == 2) at all times.

Test Plan:
- DEBOUNCE_CYCLES=4 for all scenarios. Reset for 2 cycles → all outputs 0; digits_valid=0; no entry_pulse for 20 cycles with key_n=1.
- sw=4'h4, key_n low (clean) at edge 0 → single entry_pulse at edge 5; digits=8'h04, count=1. Release, sw=4'h3, press again → digits=8'h43, digits_valid=1, count=2.
- Bounce: key_n toggles low/high every 2 cycles for 20 cycles, then stays high → no entry_pulse, digits unchanged. Then key_n low 3 cycles → no entry; low 4+ cycles → exactly one entry.
- From FULL (8'h43), sw=4'h9, press → digits=8'h09, count=1, digits_valid=0.
- clr_n low 1 cycle while count=2 → digits=0, count=0 three edges later. Debounced press landing on the same edge as clr_s low → entry_pulse=0, state EMPTY.
- key_n held low through reset and after release → exactly one entry at edge DEBOUNCE_CYCLES+1 after release; no second entry while held for 50 cycles.
